uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Serial receive front end that sits directly upstream of the controller.
- Converts the asynchronous rxd line into parallel bytes, using 8N1 framing with LSB first.
- Each accepted byte goes to the controller's word input with a one-cycle valid strobe.
- Malformed frames are reported instead of delivered.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit period (50 MHz / 115200). Legal minimum 8.
- CNT_W, 16: width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- word  output  8  last accepted data byte.
- word_valid  output  1  one-cycle pulse when word is updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high while any frame is in progress (state != IDLE).

Behaviour:
- Reset (rst low, async) forces:
  - state=IDLE;
  - word=8'h00, word_valid=0, frame_err=0, busy=0;
  - bit counter=0, bit index=0;
  - synchroniser flops=1.
- Synchroniser: rxd passes through two flops (rxd_s). All decisions use rxd_s, so there are 2 cycles of input latency.
- IDLE:
  - rxd_s==0 → START, counter cleared.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division), then sample rxd_s.
  - Sample 0 → DATA, counter cleared, bit index 0.
  - Sample 1 → glitch: return to IDLE. No pulse.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rxd_s into shift register bit[index]; bit 0 is received first.
  - Index 7 sampled → STOP; otherwise index+1.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - Sample 1: word<=shift register and word_valid=1 on the next cycle, for exactly one cycle; → IDLE.
  - Sample 0: frame_err=1 for one cycle, word unchanged; → WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxd_s==1, then → IDLE. This prevents a break condition (line held low) from being decoded as repeated 0x00 frames.
- Counter: wraps to 0 on every sample point. It never exceeds CLKS_PER_BIT-1.
- Latency: from the rxd falling edge to the word_valid rising edge = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for synchroniser phase).
- A start edge arriving in the same cycle as the transition to IDLE is seen on the following cycle. Back-to-back frames (stop immediately followed by start) must be received without loss.
- word_valid and frame_err are never asserted together.
- word holds its value between frames.
- Reset mid-frame aborts the frame immediately. No pulse is emitted, and word returns to 0.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; it samples one bit after CLKS_PER_BIT cycles.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - A mismatch sets a sticky internal flag. At the STOP sample, a good stop with bad parity pulses output parity_err (extra 1-bit port) instead of word_valid, and word is unchanged.
  - A bad stop reports frame_err only.
  - parity_err resets to 0.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err port. Behaviour is exactly 8N1 as above.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
- Reset: hold rst=0 with rxd toggling → word=8'h00, word_valid=0, frame_err=0, busy=0. Release → still IDLE while rxd=1.
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) → exactly one word_valid pulse, word=8'hA5, busy low within 1 cycle after.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three word_valid pulses in order with matching word values, no frame_err.
- Glitch: rxd low for 5 cycles then high → busy rises then falls; no word_valid, no frame_err; word unchanged.
- Framing error: frame 0x55 with stop bit 0, line held low for 40 more cycles, then high → one frame_err pulse, word unchanged. The next valid frame 0x81 yields word=8'h81.
- Reset mid-frame: assert rst during bit 4 of 0xF0 → immediate IDLE, word=0, no pulse. The next frame 0x0F is received correctly. With UART_RX_PARITY_EN, frame 0x01 with parity bit 0 → parity_err pulse, no word_valid.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// 8N1 serial receive front end (LSB first). It synchronises the asynchronous
// rxd line, finds the start edge, samples each bit in the middle of its bit
// period, and hands each good byte to the downstream controller with a
// one-cycle word_valid strobe. A frame whose stop bit is low is not
// delivered. Instead, frame_err pulses, and the receiver waits for the line
// to return high before it looks for a new start edge.
//
// Optional feature: macro UART_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits, and adds the parity_err output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rxd        serial input, idles high, asynchronous to clk
//   word       last accepted data byte (held between frames)
//   word_valid one-cycle pulse when word is updated
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   busy       high while a frame is in progress (state != IDLE)
//   parity_err one-cycle pulse on good stop with bad parity
//              (UART_RX_PARITY_EN only)
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rxd_m;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             samp;
    logic             stop_ok;
    logic             stop_bad;
    logic             deliver;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    // Two-flop synchroniser. The flops reset to the idle (high) line level,
    // so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rxd_s) state_nxt = START;
            // A start bit that is high again at mid-bit is treated as a glitch.
            START:     if (samp) state_nxt = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (samp && bit_idx == 3'd7) state_nxt = PARITY;
            PARITY:    if (samp) state_nxt = STOP;
`else
            DATA:      if (samp && bit_idx == 3'd7) state_nxt = STOP;
`endif
            STOP:      if (samp) state_nxt = rxd_s ? IDLE : WAIT_IDLE;
            // Wait out a break (line held low) so that it does not decode as
            // a run of 0x00 frames.
            WAIT_IDLE: if (rxd_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output / decode logic
    always_comb begin
        busy = (state != IDLE);
        samp = 1'b0;
        case (state)
            START:   samp = (cnt == HALF_LAST);
            DATA:    samp = (cnt == FULL_LAST);
`ifdef UART_RX_PARITY_EN
            PARITY:  samp = (cnt == FULL_LAST);
`endif
            STOP:    samp = (cnt == FULL_LAST);
            default: samp = 1'b0;
        endcase
        stop_ok  = (state == STOP) && samp && rxd_s;
        stop_bad = (state == STOP) && samp && !rxd_s;
`ifdef UART_RX_PARITY_EN
        deliver  = stop_ok && !par_bad;
`else
        deliver  = stop_ok;
`endif
    end

    // Bit-period counter and data shift register. The counter returns to 0
    // at every sample point, so every state after START begins with a fresh
    // full bit period measured from the previous mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (state == IDLE || state == WAIT_IDLE || samp) cnt <= '0;
            else                                             cnt <= cnt + 1'b1;

            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (state == DATA && samp) begin
                shreg[bit_idx] <= rxd_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity-mismatch flag. It is cleared while a new start bit is
    // being qualified. An odd count of ones over data plus parity is a
    // mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       par_bad <= 1'b0;
        else if (state == START)                        par_bad <= 1'b0;
        else if (state == PARITY && samp && ^{shreg, rxd_s}) par_bad <= 1'b1;
    end
`endif

    // Registered result strobes. Pulses appear the cycle after the stop
    // sample. They are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= 8'h00;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            word_valid <= deliver;
            frame_err  <= stop_bad;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_ok && par_bad;
`endif
            if (deliver) word <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Directed bench for uart_rx_deframer with CLKS_PER_BIT=16. Each frame sent
// pushes its expected outcome (kind, word, start cycle) onto a scoreboard.
// A monitor pops one entry per result pulse and checks the pulse kind, the
// word, busy, and the start-to-pulse latency.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif
    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         t0;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] word;
    logic       word_valid;
    logic       frame_err;
    logic       busy;
    logic       perr;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] last_word = 8'h00;
    ev_t        sb[$];

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .word       (word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.t0   = cyc;
        sb.push_back(e);
        if (kind == K_VALID) last_word = data;
    endtask

    // Drive one frame. The line is left at the stop-bit level.
    task automatic send(input logic [7:0] d, input logic stop_b);
        rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        step(CPB);
`endif
        rxd = stop_b;
        step(CPB);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 4 * CPB * 12) begin
            step(1);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst && (word_valid || frame_err || perr)) begin
                chk("pulse_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulse_kind", {29'd0, perr, frame_err, word_valid}, {29'd0, e.kind});
                    chk("pulse_word", {24'd0, word}, {24'd0, e.data});
                    chk("latency_ok", 32'((cyc - e.t0) >= LAT - 1 && (cyc - e.t0) <= LAT + 1), 1);
                    if (word_valid) chk("busy_after_valid", {31'd0, busy}, 0);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                repeat (60000) @(posedge clk);
                $display("FAIL watchdog: observed timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset held with a toggling line
        step(1);
        for (int i = 0; i < 6; i++) begin
            rxd = ~rxd;
            step(1);
        end
        chk("rst_word", {24'd0, word}, 0);
        chk("rst_word_valid", {31'd0, word_valid}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rxd = 1'b1;
        rst = 1'b1;
        step(10);
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_word", {24'd0, word}, 0);

        // Single frame
        expect_ev(K_VALID, 8'hA5);
        send(8'hA5, 1'b1);
        rxd = 1'b1;
        step(1);
        chk("a5_busy_low", {31'd0, busy}, 0);
        drain("a5_drain");
        step(10);

        // Back-to-back frames with no idle gap
        expect_ev(K_VALID, 8'h00);
        send(8'h00, 1'b1);
        expect_ev(K_VALID, 8'hFF);
        send(8'hFF, 1'b1);
        expect_ev(K_VALID, 8'h3C);
        send(8'h3C, 1'b1);
        rxd = 1'b1;
        drain("b2b_drain");
        chk("b2b_word", {24'd0, word}, 32'h3C);
        step(10);

        // Glitch on the start bit
        rxd = 1'b0;
        step(4);
        chk("glitch_busy_rise", {31'd0, busy}, 1);
        step(1);
        rxd = 1'b1;
        step(20);
        chk("glitch_busy_fall", {31'd0, busy}, 0);
        chk("glitch_word", {24'd0, word}, {24'd0, last_word});

        // Framing error followed by a break, then a good frame
        expect_ev(K_FERR, last_word);
        send(8'h55, 1'b0);
        step(40);
        chk("break_busy", {31'd0, busy}, 1);
        rxd = 1'b1;
        step(5);
        chk("break_end_busy", {31'd0, busy}, 0);
        drain("ferr_drain");
        chk("ferr_word", {24'd0, word}, 32'h3C);
        expect_ev(K_VALID, 8'h81);
        send(8'h81, 1'b1);
        rxd = 1'b1;
        drain("x81_drain");
        step(10);

        // Reset during bit 4 of 0xF0
        rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0;
            step(CPB);
        end
        rxd = 1'b1;
        step(CPB / 2);
        rst = 1'b0;
        #1;
        chk("midrst_word", {24'd0, word}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_pulse", {30'd0, word_valid, frame_err}, 0);
        last_word = 8'h00;
        step(2);
        rst = 1'b1;
        step(20);
        chk("midrst_idle", {31'd0, busy}, 0);
        expect_ev(K_VALID, 8'h0F);
        send(8'h0F, 1'b1);
        rxd = 1'b1;
        drain("x0f_drain");
        step(10);

`ifdef UART_RX_PARITY_EN
        // Bad parity with a good stop, then a clean frame
        par_flip = 1'b1;
        expect_ev(K_PERR, last_word);
        send(8'h01, 1'b1);
        rxd = 1'b1;
        par_flip = 1'b0;
        drain("perr_drain");
        chk("perr_word", {24'd0, word}, 32'h0F);
        step(10);
        expect_ev(K_VALID, 8'h02);
        send(8'h02, 1'b1);
        rxd = 1'b1;
        drain("par_ok_drain");
        step(10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
